// File: rtl/uart_hex_pkg.sv
// Shared constants, FSM encoding and ASCII-hex decode for the UART hex-word loader.
package uart_hex_pkg;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] BANG     = 8'h21;
  localparam logic [7:0] QMARK    = 8'h3F;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_R_LC = 8'h72;

  typedef enum logic [1:0] {StIdle, StProc, StEcho} state_e;

  // Returns {valid, nib}; letters map via low nibble + 9 ('A' = 0x41 -> 0xA).
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, 4'(c[3:0] + 4'd9)};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_hex_classify.sv
// Combinational byte classifier: hex digit, separator or restart command.
module uart_hex_classify
  import uart_hex_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_hex,
  output logic       is_sep,
  output logic       is_cmd_r,
  output logic [3:0] nib
);

  always_comb begin
    {is_hex, nib} = hex_to_nib(data);
    is_sep        = (data == CR) || (data == LF) || (data == SPACE);
    is_cmd_r      = (data == CMD_R) || (data == CMD_R_LC);
  end

endmodule

// File: rtl/uart_hex_loader.sv
// Packs ASCII hex characters from a UART receiver into words written to consecutive
// memory addresses, echoing each byte and flagging illegal characters.
module uart_hex_loader
  import uart_hex_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ECHO   = 1,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ack,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [3:0]        last_nibble
);

  localparam int unsigned NIBS   = WORD_W / 4;
  localparam int unsigned NCNT_W = $clog2(NIBS + 1);

  state_e              state;
  logic [7:0]          rx_byte;
  logic [WORD_W-1:0]   shift;
  logic [WORD_W-1:0]   shift_nx;
  logic [ADDR_W-1:0]   ptr;
  logic [NCNT_W-1:0]   nib_cnt;
  logic                word_full;
  logic [7:0]          echo_char;

  logic                cls_hex;
  logic                cls_sep;
  logic                cls_cmd_r;
  logic [3:0]          cls_nib;

  uart_hex_classify u_classify (
    .data     (rx_byte),
    .is_hex   (cls_hex),
    .is_sep   (cls_sep),
    .is_cmd_r (cls_cmd_r),
    .nib      (cls_nib)
  );

  assign shift_nx  = (shift << 4) | WORD_W'(cls_nib);
  assign word_full = (nib_cnt == NCNT_W'(NIBS - 1));

  always_comb begin
    echo_char = QMARK;
    if (cls_hex) begin
      echo_char = done ? BANG : rx_byte;
    end else if (cls_sep) begin
      echo_char = rx_byte;
    end else if (cls_cmd_r) begin
      echo_char = CMD_R;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      rx_byte     <= '0;
      shift       <= '0;
      ptr         <= '0;
      nib_cnt     <= '0;
      rx_ack      <= 1'b0;
      tx_data     <= '0;
      tx_wr       <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      word_count  <= '0;
      last_nibble <= '0;
    end else begin
      rx_ack <= 1'b0;
      mem_we <= 1'b0;
      tx_wr  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rx_valid) begin
            rx_byte <= rx_data;
            rx_ack  <= 1'b1;
            state   <= StProc;
          end
        end
        StProc: begin
          state <= (ECHO != 0) ? StEcho : StIdle;
          if (cls_hex && !done) begin
            shift       <= shift_nx;
            last_nibble <= cls_nib;
            if (word_full) begin
              mem_we     <= 1'b1;
              mem_addr   <= ptr;
              mem_wdata  <= shift_nx;
              word_count <= word_count + 1'b1;
              nib_cnt    <= '0;
              if (ptr == ADDR_W'(DEPTH - 1)) begin
                ptr  <= '0;
                done <= 1'b1;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end else begin
              nib_cnt <= nib_cnt + 1'b1;
            end
          end else if (cls_cmd_r) begin
            ptr        <= '0;
            nib_cnt    <= '0;
            shift      <= '0;
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
          end else if (!cls_hex && !cls_sep) begin
            err     <= 1'b1;
            nib_cnt <= '0;
          end
          // Busy is sampled here so an idle transmitter gets its strobe right after PROC.
          if (ECHO != 0) begin
            tx_data <= echo_char;
            tx_wr   <= !tx_busy;
          end
        end
        StEcho: begin
          if (tx_wr) begin
            state <= StIdle;
          end else if (!tx_busy) begin
            tx_wr <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
